// File: rtl/gpu_pkg.sv
// gpu_pkg: shared command-word layout, opcodes and screen defaults for sprite slots
package gpu_pkg;
  localparam int CMD_W = 27;
  localparam int OP_HI = 26;
  localparam int OP_LO = 23;
  localparam int PL_W = 23;
  localparam int POS_X_LO = 10;
  localparam int POS_Y_LO = 0;
  localparam int SIZE_W_LO = 6;
  localparam int SIZE_H_LO = 0;
  localparam int COLOUR_LO = 0;
  localparam int ENABLE_BIT = 0;
  localparam int VEL_X_LO = 8;
  localparam int VEL_Y_LO = 0;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  typedef enum logic [3:0] {
    OP_NOP        = 4'd0,
    OP_SET_POS    = 4'd1,
    OP_SET_SIZE   = 4'd2,
    OP_SET_COLOUR = 4'd3,
    OP_SET_ENABLE = 4'd4,
    OP_SET_VEL    = 4'd5
  } opcode_e;
endpackage

// File: rtl/sprite_wrap_add.sv
// sprite_wrap_add: 10-bit coordinate plus signed 8-bit delta, wrapped once into [0, MOD)
module sprite_wrap_add #(
  parameter int MOD = 640
) (
  input  logic        [9:0] coord,
  input  logic signed [7:0] delta,
  output logic        [9:0] sum
);
  localparam logic signed [10:0] M = 11'(MOD);
  logic signed [10:0] s;
  assign s = $signed({1'b0, coord}) + $signed({{3{delta[7]}}, delta});
  assign sum = 10'(s < 11'sd0 ? s + M : (s >= M ? s - M : s));
endmodule

// File: rtl/sprite_controller.sv
// sprite_controller: per-slot sprite registers, per-frame motion with wrap, registered pixel hit (optional SPRITE_SHADOW_EN double-buffering)
module sprite_controller
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Write,
  input  logic [CMD_W-1:0] DataIn,
  input  logic             FrameStart,
  input  logic [9:0]       PixelX,
  input  logic [9:0]       PixelY,
  output logic             PixelHit,
  output logic [7:0]       PixelColour
);
  logic [3:0] op;
  logic [PL_W-1:0] pl;
  logic unused_pl;
  logic [9:0] x, y, nx, ny, new_x, new_y;
  logic [5:0] w, h;
  logic [7:0] colour;
  logic en;
  logic signed [7:0] vx, vy, step_vx, step_vy;
  logic pos_ok, wr_size, wr_col, wr_en, wr_vel, hit;
  assign op = DataIn[OP_HI:OP_LO];
  assign pl = DataIn[PL_W-1:0];
  assign unused_pl = ^pl[22:20];
  assign new_x = pl[POS_X_LO +: 10];
  assign new_y = pl[POS_Y_LO +: 10];
  assign pos_ok = Write && op == OP_SET_POS && new_x < 10'(SCREEN_W) && new_y < 10'(SCREEN_H);
  assign wr_size = Write && op == OP_SET_SIZE;
  assign wr_col = Write && op == OP_SET_COLOUR;
  assign wr_en = Write && op == OP_SET_ENABLE;
  assign wr_vel = Write && op == OP_SET_VEL;
  sprite_wrap_add #(.MOD(SCREEN_W)) u_wrap_x (.coord(x), .delta(step_vx), .sum(nx));
  sprite_wrap_add #(.MOD(SCREEN_H)) u_wrap_y (.coord(y), .delta(step_vy), .sum(ny));
`ifdef SPRITE_SHADOW_EN
  logic [9:0] sx, sy;
  logic [5:0] sw, sh;
  logic [7:0] sc;
  logic se, pend;
  logic signed [7:0] svx, svy;
  assign step_vx = svx;
  assign step_vy = svy;
  // Shadow capture; pend marks a position that replaces the next frame's step
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {sx, sy, sw, sh, sc, se, svx, svy, pend} <= '0;
    end else begin
      if (pos_ok) begin
        sx <= new_x;
        sy <= new_y;
      end
      if (wr_size) begin
        sw <= pl[SIZE_W_LO +: 6];
        sh <= pl[SIZE_H_LO +: 6];
      end
      if (wr_col) sc <= pl[COLOUR_LO +: 8];
      if (wr_en) se <= pl[ENABLE_BIT];
      if (wr_vel) begin
        svx <= pl[VEL_X_LO +: 8];
        svy <= pl[VEL_Y_LO +: 8];
      end
      pend <= pos_ok | (pend & ~FrameStart);
    end
  end
  // Commit shadow at frame start; committed velocity drives the step unless a position was committed
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {x, y, w, h, colour, en, vx, vy} <= '0;
    end else if (FrameStart) begin
      w <= sw;
      h <= sh;
      colour <= sc;
      en <= se;
      vx <= svx;
      vy <= svy;
      x <= pend ? sx : nx;
      y <= pend ? sy : ny;
    end
  end
`else
  assign step_vx = vx;
  assign step_vy = vy;
  // Direct register writes; a written position overrides the frame step
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {x, y, w, h, colour, en, vx, vy} <= '0;
    end else begin
      if (FrameStart) begin
        x <= nx;
        y <= ny;
      end
      if (pos_ok) begin
        x <= new_x;
        y <= new_y;
      end
      if (wr_size) begin
        w <= pl[SIZE_W_LO +: 6];
        h <= pl[SIZE_H_LO +: 6];
      end
      if (wr_col) colour <= pl[COLOUR_LO +: 8];
      if (wr_en) en <= pl[ENABLE_BIT];
      if (wr_vel) begin
        vx <= pl[VEL_X_LO +: 8];
        vy <= pl[VEL_Y_LO +: 8];
      end
    end
  end
`endif
  assign hit = en
    && {1'b0, PixelX} >= {1'b0, x} && {1'b0, PixelX} <= {1'b0, x} + {5'b0, w}
    && {1'b0, PixelY} >= {1'b0, y} && {1'b0, PixelY} <= {1'b0, y} + {5'b0, h};
  // Hit flag and colour, one cycle behind the scan position
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PixelHit <= 1'b0;
      PixelColour <= '0;
    end else begin
      PixelHit <= hit;
      PixelColour <= hit ? colour : '0;
    end
  end
endmodule

// File: tb/tb_sprite_controller.sv
// tb_sprite_controller: scoreboard bench with a behavioural sprite model (honours SPRITE_SHADOW_EN)
module tb_sprite_controller;
  localparam int SW = 640;
  localparam int SH = 480;
  logic Clk = 0, Reset = 1, Write = 0, FrameStart = 0;
  logic [26:0] DataIn = '0;
  logic [9:0] PixelX = '0, PixelY = '0;
  logic PixelHit;
  logic [7:0] PixelColour;
  sprite_controller #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .Clk(Clk), .Reset(Reset), .Write(Write), .DataIn(DataIn), .FrameStart(FrameStart),
    .PixelX(PixelX), .PixelY(PixelY), .PixelHit(PixelHit), .PixelColour(PixelColour)
  );
  always #5 Clk = ~Clk;

  typedef struct {
    logic hit;
    logic [7:0] col;
    string tag;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int mx, my, mw, mh, mc, me, mvx, mvy;
  int sx, sy, sw, sh, sc, se, svx, svy, spend;

  function automatic int wrapm(int v, int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic bit model_hit(int px, int py);
    return me != 0 && px >= mx && px <= mx + mw && py >= my && py <= my + mh;
  endfunction

  task automatic model_reset();
    {mx, my, mw, mh, mc, me, mvx, mvy} = '0;
    {sx, sy, sw, sh, sc, se, svx, svy, spend} = '0;
  endtask

  task automatic model_edge(logic wr, logic [3:0] op, logic [22:0] pl, logic fs);
    int px = int'(pl[19:10]);
    int py = int'(pl[9:0]);
    bit pv = wr && op == 4'd1 && px < SW && py < SH;
    if (Reset) begin
      model_reset();
      return;
    end
`ifdef SPRITE_SHADOW_EN
    if (fs) begin
      mw = sw; mh = sh; mc = sc; me = se; mvx = svx; mvy = svy;
      if (spend != 0) begin
        mx = sx; my = sy;
      end else begin
        mx = wrapm(mx + mvx, SW); my = wrapm(my + mvy, SH);
      end
      spend = 0;
    end
    if (pv) begin sx = px; sy = py; spend = 1; end
    if (wr && op == 4'd2) begin sw = int'(pl[11:6]); sh = int'(pl[5:0]); end
    if (wr && op == 4'd3) sc = int'(pl[7:0]);
    if (wr && op == 4'd4) se = int'(pl[0]);
    if (wr && op == 4'd5) begin svx = int'($signed(pl[15:8])); svy = int'($signed(pl[7:0])); end
`else
    if (fs && !pv) begin
      mx = wrapm(mx + mvx, SW); my = wrapm(my + mvy, SH);
    end
    if (pv) begin mx = px; my = py; end
    if (wr && op == 4'd2) begin mw = int'(pl[11:6]); mh = int'(pl[5:0]); end
    if (wr && op == 4'd3) mc = int'(pl[7:0]);
    if (wr && op == 4'd4) me = int'(pl[0]);
    if (wr && op == 4'd5) begin mvx = int'($signed(pl[15:8])); mvy = int'($signed(pl[7:0])); end
`endif
  endtask

  task automatic step(input logic wr, input logic [3:0] op, input logic [22:0] pl, input logic fs,
                      input int px, input int py, input string tag);
    exp_t e;
    @(negedge Clk);
    Write = wr;
    DataIn = {op, pl};
    FrameStart = fs;
    PixelX = 10'(px);
    PixelY = 10'(py);
    e.hit = !Reset && model_hit(px, py);
    e.col = e.hit ? 8'(mc) : 8'h00;
    e.tag = tag;
    q.push_back(e);
    model_edge(wr, op, pl, fs);
  endtask

  task automatic cmd(input logic [3:0] op, input logic [22:0] pl);
    step(1'b1, op, pl, 1'b0, 1023, 1023, "cmd");
  endtask

  task automatic scan(input int px, input int py, input string tag);
    step(1'b0, 4'd0, 23'd0, 1'b0, px, py, tag);
  endtask

  task automatic frame();
    step(1'b0, 4'd0, 23'd0, 1'b1, 1023, 1023, "frame");
  endtask

  function automatic logic [22:0] pos(int x, int y);
    return 23'((x & 1023) * 1024 + (y & 1023));
  endfunction
  function automatic logic [22:0] size(int w, int h);
    return 23'((w & 63) * 64 + (h & 63));
  endfunction
  function automatic logic [22:0] vel(int vx, int vy);
    return 23'(((vx & 255) << 8) | (vy & 255));
  endfunction

  // Monitor: output is presented every cycle, compared shortly after each edge
  always @(posedge Clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if (PixelHit !== e.hit || PixelColour !== e.col) begin
        mismatched++;
        $display("FAIL %s: got hit=%0b colour=%02h, expected hit=%0b colour=%02h at %0t",
                 e.tag, PixelHit, PixelColour, e.hit, e.col, $time);
      end
    end
  end

  initial begin
    model_reset();
    scan(0, 0, "reset");
    scan(0, 0, "reset");
    Reset = 0;
    scan(0, 0, "after_reset");
    cmd(4'd1, pos(100, 50));
    cmd(4'd2, size(7, 3));
    cmd(4'd3, 23'h0000A5);
    cmd(4'd4, 23'd1);
    scan(100, 50, "hit_origin");
    scan(108, 50, "miss_right");
    scan(107, 53, "hit_corner");
    scan(99, 50, "miss_left");
    scan(100, 54, "miss_below");
    cmd(4'd4, 23'd0);
    scan(101, 51, "disabled");
    cmd(4'd4, 23'd1);
    cmd(4'd2, size(0, 0));
    cmd(4'd1, pos(635, 50));
    cmd(4'd5, vel(10, 0));
    frame();
    scan(5, 50, "wrap_x_pos");
    scan(635, 50, "wrap_x_old");
    cmd(4'd1, pos(3, 50));
    cmd(4'd5, vel(-5, 0));
    frame();
    scan(638, 50, "wrap_x_neg");
    cmd(4'd1, pos(100, 478));
    cmd(4'd5, vel(0, 4));
    frame();
    scan(100, 2, "wrap_y_pos");
    cmd(4'd1, pos(700, 10));
    scan(100, 2, "bad_pos_kept");
    cmd(4'd9, 23'h7FFFFF);
    scan(100, 2, "op9_ignored");
    cmd(4'd2, size(63, 63));
    cmd(4'd1, pos(620, 470));
    scan(639, 479, "clip_in");
    scan(683, 479, "clip_beyond");
    scan(625, 5, "clip_nowrap");
    cmd(4'd2, size(0, 0));
    cmd(4'd5, vel(5, 0));
    step(1'b1, 4'd1, pos(20, 20), 1'b1, 1023, 1023, "pos_with_frame");
    scan(20, 20, "pos_wins");
    scan(25, 20, "pos_no_step");
    frame();
    scan(20, 20, "shadow_between");
    scan(25, 20, "stepped");
    step(1'b1, 4'd5, vel(3, 0), 1'b1, 1023, 1023, "vel_with_frame");
    scan(30, 20, "old_vel_used");
    frame();
    scan(33, 20, "new_vel_used");
    frame();
    scan(36, 20, "third_frame");
    cmd(4'd5, vel(0, 0));
    cmd(4'd3, 23'h00003C);
    frame();
    frame();
    scan(mx, my, "pre_reset_hit");
    @(negedge Clk);
    Reset = 1;
    #1;
    compared++;
    if (PixelHit !== 1'b0 || PixelColour !== 8'h00) begin
      mismatched++;
      $display("FAIL async_reset: got hit=%0b colour=%02h, expected hit=0 colour=00", PixelHit, PixelColour);
    end
    model_reset();
    scan(0, 0, "in_reset");
    Reset = 0;
    scan(0, 0, "post_reset");
    cmd(4'd4, 23'd1);
    frame();
    scan(0, 0, "reset_pos_hit");
    scan(1, 0, "reset_size_miss");
    scan(0, 1, "reset_size_miss_y");
    for (int i = 0; i < 3000; i++) begin
      logic wr, fs;
      logic [3:0] op;
      logic [22:0] pl;
      int px, py;
      wr = $urandom_range(0, 9) < 3;
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
      pl = 23'($urandom);
      if (op == 4'd1 && $urandom_range(0, 9) < 8) pl = pos($urandom_range(0, SW - 1), $urandom_range(0, SH - 1));
      if (op == 4'd4 && $urandom_range(0, 3) != 0) pl[0] = 1'b1;
      fs = $urandom_range(0, 19) == 0;
      px = mx - 4 + $urandom_range(0, 75);
      py = my - 4 + $urandom_range(0, 75);
      px = px < 0 ? 0 : (px > 1023 ? 1023 : px);
      py = py < 0 ? 0 : (py > 1023 ? 1023 : py);
      step(wr, op, pl, fs, px, py, "random");
    end
    scan(1023, 1023, "drain");
    repeat (3) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sprite_controller.md
# sprite_controller

Per-sprite register and pixel-hit stage sitting directly downstream of the GPU input decoder; one instance per sprite slot, 256 instances in total. Each instance accepts a one-hot write strobe plus the 27-bit command word {opcode, payload}, and holds position, size, colour, enable and velocity. It applies velocity once per frame with screen wrap-around. Against the scan position it produces a registered hit flag and colour for the pixel mixer.

## Interface
Parameters:
- SCREEN_W, 640, horizontal wrap modulus
- SCREEN_H, 480, vertical wrap modulus

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Write  in  1  this slot's bit of the decoder write bus; command valid this cycle
- DataIn  in  27  [26:23] opcode, [22:0] payload
- FrameStart  in  1  single-cycle pulse at start of frame
- PixelX  in  10  current scan column
- PixelY  in  10  current scan row
- PixelHit  out  1  registered: previous-cycle pixel lies inside an enabled sprite
- PixelColour  out  8  registered: sprite colour when PixelHit, else 0

## Operation
- Opcodes are decoded only when Write=1:
  - 0 NOP.
  - 1 SET_POS: X=payload[19:10], Y=payload[9:0].
  - 2 SET_SIZE: W=payload[11:6], H=payload[5:0]; the sprite spans W+1 by H+1 pixels.
  - 3 SET_COLOUR: payload[7:0].
  - 4 SET_ENABLE: payload[0].
  - 5 SET_VEL: VX=signed payload[15:8], VY=signed payload[7:0].
  - 6–15: ignored, no state change.
- SET_POS with X≥SCREEN_W or Y≥SCREEN_H is discarded entirely; both X and Y stay unchanged.
- Velocity step on FrameStart:
  - X ← (X+VX) mod SCREEN_W; Y ← (Y+VY) mod SCREEN_H.
  - Sums use 11-bit signed arithmetic. A negative result has the modulus added once; a result ≥ the modulus has it subtracted once. A single correction always suffices because |V|≤128.
- Hit test: X ≤ PixelX ≤ X+W and Y ≤ PixelY ≤ Y+H, evaluated in 11 bits with no wrap.
  - A sprite overlapping the right or bottom edge is clipped, not wrapped.
  - Requires Enable=1.
- Reset values: X=Y=W=H=0, VX=VY=0, Colour=0, Enable=0; PixelHit=0, PixelColour=0. Any shadow state also resets to 0.
- Reset asserted mid-frame clears everything immediately. PixelHit stays 0 until an enable write takes effect.

## Timing
- Hit latency: 1 cycle. PixelHit/PixelColour at cycle n+1 reflect PixelX/PixelY and the active registers at edge n.
- Register write (no shadow): active from the cycle after Write.
- FrameStart together with SET_POS: the written position wins and no velocity step is applied that frame.
- FrameStart together with SET_VEL: the step uses the old velocity; the new velocity applies from the next frame.
- Back-to-back writes on consecutive cycles are all accepted; there is no backpressure.

## Configuration
- SPRITE_SHADOW_EN defined:
  - All writes land in shadow registers. Shadow is copied to active registers on FrameStart, and the copy happens before the velocity step.
  - A SET_POS commit suppresses that frame's step.
  - A write coincident with FrameStart stays in shadow until the next FrameStart.
  - Hit logic uses active registers only, so no mid-frame tearing.
- SPRITE_SHADOW_EN undefined: no shadow registers; writes update the active registers directly as in Timing.

## Structure
- Shared package gpu_pkg holds:
  - opcode constants OP_NOP through OP_SET_VEL
  - payload field bit positions
  - SCREEN_W/SCREEN_H defaults
  - command width 27
- Sub-module sprite_wrap_add, instantiated twice (X and Y): 10-bit coordinate plus signed 8-bit delta, modulus parameter, returning the wrapped coordinate.

## Test plan
- Reset, then SET_POS(100,50), SET_SIZE(7,3), SET_COLOUR(0xA5), SET_ENABLE(1); scan (100,50) → next cycle PixelHit=1, PixelColour=0xA5. Scan (108,50) → 0/0x00. Scan (107,53) → 1.
- Enabled sprite with SET_ENABLE(0), scan inside its area → PixelHit=0, PixelColour=0.
- Wrap: X=635, VX=+10, FrameStart → X=5. X=3, VX=−5 → X=638. Y=478, VY=+4 → Y=2.
- SET_POS(700,10) → ignored, previous position retained. Opcode 9 → no state change.
- Write and FrameStart coincide:
  - SET_POS(20,20) with VX=5 → X=20 without shadow.
  - With SPRITE_SHADOW_EN: the active position is unchanged until the second FrameStart; a scan between the two FrameStarts still hits the old area.
- Reset asserted mid-scan with PixelHit=1 → PixelHit=0 asynchronously; all registers read back as their reset values.
